serial_frame_tx: RTL and testbench



---
 rtl/serial_frame_tx.sv | 109 ++++++++++
 tb/tb_serial_frame_tx.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out frame transmitter: start bit (0), DATA_W data bits LSB first,
// stop bit (1), each bit held for BIT_CYCLES clocks. All outputs are registered.
module serial_frame_tx #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  output logic              serial_out,
  output logic              busy,
  output logic              done
);

  localparam int TW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [TW-1:0] TLAST = TW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] ILAST = IW'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] sr_q;
  logic [TW-1:0]     tcnt_q;
  logic [IW-1:0]     bidx_q;
  logic              line_q;
  logic              busy_q;
  logic              done_q;

  logic              bit_end;
  logic [DATA_W-1:0] sr_sh;

  assign bit_end = (tcnt_q == TLAST);
  assign sr_sh   = sr_q >> 1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      tcnt_q  <= '0;
      bidx_q  <= '0;
      line_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          line_q <= 1'b1;
          busy_q <= 1'b0;
          if (load) begin
            sr_q    <= data_in;
            tcnt_q  <= '0;
            state_q <= START;
            busy_q  <= 1'b1;
            line_q  <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            tcnt_q  <= '0;
            bidx_q  <= '0;
            state_q <= DATA;
            line_q  <= sr_q[0];
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            sr_q   <= sr_sh;
            tcnt_q <= '0;
            if (bidx_q == ILAST) begin
              state_q <= STOP;
              line_q  <= 1'b1;
            end else begin
              bidx_q <= bidx_q + IW'(1);
              line_q <= sr_sh[0];
            end
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end
        STOP: begin
          // Frame completes here; the done pulse self-clears on the following edge.
          if (bit_end) begin
            tcnt_q  <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          line_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign serial_out = line_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: default instance (8 bits, 4 clocks/bit)
// and a 1-bit, 1-clock/bit corner instance.
module tb_serial_frame_tx;

  logic       clock = 1'b0;
  logic       reset;
  logic       load;
  logic [7:0] data_in;
  logic       serial_out, busy, done;
  logic       load1;
  logic [0:0] din1;
  logic       so1, busy1, done1;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;
  int d1, d2, dx;

  always #5 clock = ~clock;

  serial_frame_tx #(.DATA_W(8), .BIT_CYCLES(4)) u_dut (
    .clock(clock), .reset(reset), .load(load), .data_in(data_in),
    .serial_out(serial_out), .busy(busy), .done(done)
  );

  serial_frame_tx #(.DATA_W(1), .BIT_CYCLES(1)) u_dut1 (
    .clock(clock), .reset(reset), .load(load1), .data_in(din1),
    .serial_out(so1), .busy(busy1), .done(done1)
  );

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected line level i clocks after the accepting edge (default parameters).
  function automatic logic fbit(input logic [7:0] v, input int i);
    int j;
    j = i / 4;
    if (j == 0) return 1'b0;
    if (j <= 8) return v[j-1];
    return 1'b1;
  endfunction

  // Caller sets load/data_in; the first tick is the accepting edge.
  task automatic run_frame(input logic [7:0] v, input string tag, input bit hold,
                           input logic [7:0] next_d, input int inj_on, output int done_at);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 0) begin
        if (!hold) load = 1'b0;
        data_in = next_d;
      end
      if (inj_on >= 0 && i == inj_on) begin
        load    = 1'b1;
        data_in = 8'hFF;
      end
      if (inj_on >= 0 && i == inj_on + 4) load = 1'b0;
      chk($sformatf("%s line c%0d", tag, i), serial_out, fbit(v, i));
      chk($sformatf("%s busy c%0d", tag, i), busy, 1'b1);
      chk($sformatf("%s done c%0d", tag, i), done, 1'b0);
    end
    tick();
    chk($sformatf("%s end busy", tag), busy, 1'b0);
    chk($sformatf("%s end done", tag), done, 1'b1);
    chk($sformatf("%s end line", tag), serial_out, 1'b1);
    done_at = cyc;
  endtask

  initial begin
    reset   = 1'b1;
    load    = 1'b1;
    data_in = 8'hFF;
    load1   = 1'b0;
    din1    = 1'b0;

    // Reset with load asserted: nothing may start.
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("rst line c%0d", i), serial_out, 1'b1);
      chk($sformatf("rst busy c%0d", i), busy, 1'b0);
      chk($sformatf("rst done c%0d", i), done, 1'b0);
      chk($sformatf("rst line1 c%0d", i), so1, 1'b1);
    end
    reset = 1'b0;
    load  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("idle line c%0d", i), serial_out, 1'b1);
      chk($sformatf("idle busy c%0d", i), busy, 1'b0);
    end

    // Single frame 8'hA5.
    load    = 1'b1;
    data_in = 8'hA5;
    run_frame(8'hA5, "a5", 1'b0, 8'hA5, -1, dx);
    tick();
    chk("a5 after done", done, 1'b0);
    chk("a5 after busy", busy, 1'b0);

    // Load during a frame is ignored.
    load    = 1'b1;
    data_in = 8'h3C;
    run_frame(8'h3C, "3c", 1'b0, 8'h3C, 10, dx);
    tick();
    chk("3c after done", done, 1'b0);
    chk("3c after busy", busy, 1'b0);

    // Back-to-back with load held; data_in changes right after acceptance.
    load    = 1'b1;
    data_in = 8'h01;
    run_frame(8'h01, "b01", 1'b1, 8'h80, -1, d1);
    run_frame(8'h80, "b80", 1'b1, 8'h80, -1, d2);
    load = 1'b0;
    chk("b2b done spacing", d2 - d1, 41);
    tick();
    chk("b2b after busy", busy, 1'b0);
    chk("b2b after done", done, 1'b0);

    // Reset mid-frame abandons the frame without a done pulse.
    load    = 1'b1;
    data_in = 8'h00;
    tick();
    load = 1'b0;
    chk("mid busy c0", busy, 1'b1);
    for (int i = 1; i < 15; i++) begin
      tick();
      chk($sformatf("mid line c%0d", i), serial_out, fbit(8'h00, i));
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid rst line", serial_out, 1'b1);
    chk("mid rst busy", busy, 1'b0);
    chk("mid rst done", done, 1'b0);
    for (int i = 0; i < 30; i++) begin
      tick();
      chk($sformatf("mid quiet done c%0d", i), done, 1'b0);
      chk($sformatf("mid quiet line c%0d", i), serial_out, 1'b1);
    end
    load    = 1'b1;
    data_in = 8'h55;
    run_frame(8'h55, "55", 1'b0, 8'h55, -1, dx);
    tick();
    chk("55 after done", done, 1'b0);

    // Corner: DATA_W=1, BIT_CYCLES=1, data 1 -> line 0,1,1.
    load1 = 1'b1;
    din1  = 1'b1;
    tick();
    load1 = 1'b0;
    din1  = 1'b0;
    chk("c1 start line", so1, 1'b0);
    chk("c1 start busy", busy1, 1'b1);
    tick();
    chk("c1 data line", so1, 1'b1);
    chk("c1 data busy", busy1, 1'b1);
    tick();
    chk("c1 stop line", so1, 1'b1);
    chk("c1 stop busy", busy1, 1'b1);
    chk("c1 stop done", done1, 1'b0);
    tick();
    chk("c1 end busy", busy1, 1'b0);
    chk("c1 end done", done1, 1'b1);
    tick();
    chk("c1 after done", done1, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
